// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32x32 multiply/divide unit owning the HI/LO registers.
// Multiply is shift-add and divide is restoring shift-subtract, one bit per
// cycle, on unsigned magnitudes. A final cycle applies the sign correction.
// Optional feature: define MULDIV_DIV_EN to build div/divu. Without it, div/divu
// decode as reserved op codes and the divide datapath is absent.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;   // running partial product high half / remainder
  logic [31:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / dividend->quotient
  logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic        neg_res_q, neg_res_d; // product or quotient must be negated
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        op_md_s;
  logic        op_mt_s;
  logic        op_signed_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] mul_sum_s;
  logic [63:0] prod_s;

`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic        op_div_s;
  logic [31:0] div_low_s;
  logic        div_ge_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
`endif

  // Decode the request into iterative / move class and signedness.
  always_comb begin
    op_md_s     = 1'b0;
    op_mt_s     = 1'b0;
    op_signed_s = 1'b0;
`ifdef MULDIV_DIV_EN
    op_div_s    = 1'b0;
`endif
    case (op)
      OP_MULT: begin
        op_md_s     = 1'b1;
        op_signed_s = 1'b1;
      end
      OP_MULTU: begin
        op_md_s     = 1'b1;
      end
`ifdef MULDIV_DIV_EN
      OP_DIV: begin
        op_md_s     = 1'b1;
        op_signed_s = 1'b1;
        op_div_s    = 1'b1;
      end
      OP_DIVU: begin
        op_md_s     = 1'b1;
        op_div_s    = 1'b1;
      end
`endif
      OP_MTHI, OP_MTLO: begin
        op_mt_s     = 1'b1;
      end
      default: begin
        op_md_s     = 1'b0;
      end
    endcase
  end

  // Operand magnitudes, one multiply step and the signed product.
  assign a_mag_s   = (op_signed_s && A[31]) ? (32'd0 - A) : A;
  assign b_mag_s   = (op_signed_s && B[31]) ? (32'd0 - B) : B;
  assign mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign prod_s    = neg_res_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};

`ifdef MULDIV_DIV_EN
  // One restoring divide step; a set top remainder bit means the shifted value exceeds any divisor.
  assign div_low_s = {acc_hi_q[30:0], acc_lo_q[31]};
  assign div_ge_s  = acc_hi_q[31] | (div_low_s >= opnd_q);
  assign quo_s     = div_zero_q ? 32'hFFFF_FFFF :
                     (neg_res_q ? (32'd0 - acc_lo_q) : acc_lo_q);
  assign rem_s     = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;
`endif

  // Next-state, datapath and HI/LO update for the control FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !flush && op_md_s) begin
          state_d   = S_ITER;
          cnt_d     = 5'd0;
          acc_hi_d  = 32'd0;
          neg_res_d = op_signed_s & (A[31] ^ B[31]);
`ifdef MULDIV_DIV_EN
          is_div_d   = op_div_s;
          neg_rem_d  = op_signed_s & A[31];
          div_zero_d = (B == 32'd0);
          if (op_div_s) begin
            acc_lo_d = a_mag_s;
            opnd_d   = b_mag_s;
          end else begin
            acc_lo_d = b_mag_s;
            opnd_d   = a_mag_s;
          end
`else
          acc_lo_d = b_mag_s;
          opnd_d   = a_mag_s;
`endif
        end else if (start && !flush && op_mt_s) begin
          state_d = S_DONE;
          if (op == OP_MTHI) begin
            hi_d = A;
          end else begin
            lo_d = A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
          end else begin
            state_d = S_ITER;
          end
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            acc_hi_d = div_ge_s ? (div_low_s - opnd_q) : div_low_s;
            acc_lo_d = {acc_lo_q[30:0], div_ge_s};
          end else begin
            {acc_hi_d, acc_lo_d} = {mul_sum_s, acc_lo_q[31:1]};
          end
`else
          {acc_hi_d, acc_lo_d} = {mul_sum_s, acc_lo_q[31:1]};
`endif
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi_d = rem_s;
            lo_d = quo_s;
          end else begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end
`else
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opnd_q    <= 32'd0;
      neg_res_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q   <= is_div_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with hand-computed HI/LO, busy and done expectations.
// Divide vectors run only when MULDIV_DIV_EN is defined; otherwise div/divu must be ignored.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_hi_r;
  logic [31:0] exp_lo_r;
  int          busy_n;
  int          done_n;
  int          done_at;
  logic [31:0] hi_at;
  logic [31:0] lo_at;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    A     = 32'h5A5A_A5A5;
    B     = 32'h0F0F_F0F0;
  endtask

  // Observe ncyc cycles; sample index 0 is just after the accepting edge.
  task automatic watch(input int ncyc, input bit hammer, output int bn, output int dn,
                       output int da, output logic [31:0] ha, output logic [31:0] la);
    bn = 0;
    dn = 0;
    da = -1;
    ha = 32'h0;
    la = 32'h0;
    for (int i = 0; i < ncyc; i++) begin
      if (busy) bn++;
      if (done) begin
        dn++;
        if (da < 0) begin
          da = i;
          ha = hi;
          la = lo;
        end
      end
      if (hammer && dn == 0) begin
        start = 1'b1;
        op    = 3'b001;
        A     = $urandom;
        B     = $urandom;
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  task automatic op_test(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit runs, input bit fires,
                         input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b);
    watch(40, 1'b0, busy_n, done_n, done_at, hi_at, lo_at);
    check_val({tag, ".busy_cycles"}, 64'(busy_n), runs ? 64'd33 : 64'd0);
    check_val({tag, ".done_count"}, 64'(done_n), fires ? 64'd1 : 64'd0);
    if (fires) begin
      check_val({tag, ".done_cycle"}, 64'(done_at), runs ? 64'd33 : 64'd0);
      check_val({tag, ".hi_at_done"}, 64'(hi_at), 64'(eh));
      check_val({tag, ".lo_at_done"}, 64'(lo_at), 64'(el));
    end
    check_val({tag, ".hi"}, 64'(hi), 64'(eh));
    check_val({tag, ".lo"}, 64'(lo), 64'(el));
    exp_hi_r = eh;
    exp_lo_r = el;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    A     = 32'h0;
    B     = 32'h0;
    repeat (3) step();
    check_val("rst.hi",   64'(hi),   64'd0);
    check_val("rst.lo",   64'(lo),   64'd0);
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.done", 64'(done), 64'd0);
    reset = 1'b0;
    step();

    op_test("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    op_test("mult_m3x7", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    op_test("mult_minsq", 3'b000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_0000);
    op_test("mult_5xm4", 3'b000, 32'h0000_0005, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEC);
    op_test("multu_shift", 3'b001, 32'h1234_5678, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0001, 32'h2345_6780);
    op_test("mthi", 3'b100, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, exp_lo_r);
    op_test("mtlo", 3'b101, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, exp_hi_r, 32'hCAFE_F00D);
    op_test("rsvd110", 3'b110, 32'h1111_1111, 32'h2, 1'b0, 1'b0, exp_hi_r, exp_lo_r);
    op_test("rsvd111", 3'b111, 32'h2222_2222, 32'h3, 1'b0, 1'b0, exp_hi_r, exp_lo_r);

`ifdef MULDIV_DIV_EN
    op_test("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_test("divu_by0", 3'b011, 32'd100, 32'h0, 1'b1, 1'b1, 32'd100, 32'hFFFF_FFFF);
    op_test("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h8000_0000);
    op_test("divu_100d7", 3'b011, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
    op_test("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFD);
    op_test("div_m5by0", 3'b010, 32'hFFFF_FFFB, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
`else
    op_test("divu_off", 3'b011, 32'd9, 32'd3, 1'b0, 1'b0, exp_hi_r, exp_lo_r);
    op_test("div_off", 3'b010, 32'd9, 32'd3, 1'b0, 1'b0, exp_hi_r, exp_lo_r);
`endif

    // flush together with start in IDLE drops the request
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b100;
    A     = 32'h0000_0001;
    step();
    start = 1'b0;
    flush = 1'b0;
    watch(10, 1'b0, busy_n, done_n, done_at, hi_at, lo_at);
    check_val("flush_start.done", 64'(done_n), 64'd0);
    check_val("flush_start.hi", 64'(hi), 64'(exp_hi_r));

    // flush at the tenth edge after acceptance aborts a mult
    issue(3'b000, 32'd7, 32'd9);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flush_iter.busy", 64'(busy), 64'd0);
    watch(40, 1'b0, busy_n, done_n, done_at, hi_at, lo_at);
    check_val("flush_iter.done", 64'(done_n), 64'd0);
    check_val("flush_iter.hi", 64'(hi), 64'(exp_hi_r));
    check_val("flush_iter.lo", 64'(lo), 64'(exp_lo_r));
    op_test("mtlo5", 3'b101, 32'd5, 32'h0, 1'b0, 1'b1, exp_hi_r, 32'd5);

    // start held every cycle: only the first multu is taken
    issue(3'b001, 32'd3, 32'd5);
    watch(40, 1'b1, busy_n, done_n, done_at, hi_at, lo_at);
    check_val("hammer.busy_cycles", 64'(busy_n), 64'd33);
    check_val("hammer.done_count", 64'(done_n), 64'd1);
    check_val("hammer.hi_at_done", 64'(hi_at), 64'd0);
    check_val("hammer.lo_at_done", 64'(lo_at), 64'd15);

    // reset at the twentieth edge of a multu aborts with cleared state
    issue(3'b001, 32'h0001_1111, 32'h0002_2222);
    for (int i = 1; i < 20; i++) begin
      start = 1'b1;
      op    = 3'b001;
      A     = $urandom;
      B     = $urandom;
      step();
    end
    reset = 1'b1;
    start = 1'b0;
    step();
    check_val("reset_mid.hi",   64'(hi),   64'd0);
    check_val("reset_mid.lo",   64'(lo),   64'd0);
    check_val("reset_mid.busy", 64'(busy), 64'd0);
    check_val("reset_mid.done", 64'(done), 64'd0);
    reset = 1'b0;
    watch(40, 1'b0, busy_n, done_n, done_at, hi_at, lo_at);
    check_val("reset_mid.later_done", 64'(done_n), 64'd0);
    check_val("reset_mid.later_busy", 64'(busy_n), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
